// File: rtl/idma_pkg.sv
// Shared iDMA types used by the error-collection path.
package idma_pkg;

    // Error source tag as carried on the report bus.
    typedef logic [1:0] err_type_t;

    typedef enum logic [1:0] {
        BUS_READ  = 2'd0,
        BUS_WRITE = 2'd1,
        BACKEND   = 2'd2
    } err_type_e;

    typedef enum logic [0:0] {
        CONTINUE = 1'b0,
        ABORT    = 1'b1
    } eh_action_e;

    typedef enum logic [0:0] {
        NO_ERROR_HANDLING = 1'b0,
        ERROR_HANDLING    = 1'b1
    } error_cap_e;

    typedef struct packed {
        logic buffer_busy;
        logic r_dp_busy;
        logic w_dp_busy;
        logic r_leg_busy;
        logic w_leg_busy;
        logic eh_fsm_busy;
        logic eh_cnt_busy;
        logic raw_coupler_busy;
    } idma_busy_t;

    // Full-width report; users keep only the low AddrWidth address bits.
    typedef struct packed {
        err_type_t   err_type;
        logic [63:0] addr;
    } idma_err_report_t;

    // Error-handler FSM states (prefixed to stay clear of eh_action_e names).
    typedef enum logic [1:0] {
        EH_IDLE     = 2'd0,
        EH_REPORT   = 2'd1,
        EH_WAIT_ACT = 2'd2,
        EH_ABORT    = 2'd3
    } eh_state_e;

endpackage

// File: rtl/idma_err_collector_if.sv
// Error-report bundle between transport legs, collector and frontend.
interface idma_err_collector_if import idma_pkg::*; #(
    parameter int unsigned AddrWidth = 32
) ();
    logic                 r_err_valid_i;
    logic [AddrWidth-1:0] r_err_addr_i;
    logic                 r_err_ready_o;
    logic                 w_err_valid_i;
    logic [AddrWidth-1:0] w_err_addr_i;
    logic                 w_err_ready_o;
    logic                 be_err_valid_i;
    logic [AddrWidth-1:0] be_err_addr_i;
    logic                 be_err_ready_o;
    logic                 err_valid_o;
    err_type_t            err_type_o;
    logic [AddrWidth-1:0] err_addr_o;
    logic                 err_ready_i;
    logic                 eh_valid_i;
    eh_action_e           eh_i;
    logic                 eh_ready_o;
    logic                 abort_o;
    logic                 fsm_busy_o;
    logic                 cnt_busy_o;

    // Collector side.
    modport slave (
        input  r_err_valid_i, r_err_addr_i, w_err_valid_i, w_err_addr_i,
               be_err_valid_i, be_err_addr_i, err_ready_i, eh_valid_i, eh_i,
        output r_err_ready_o, w_err_ready_o, be_err_ready_o, err_valid_o,
               err_type_o, err_addr_o, eh_ready_o, abort_o, fsm_busy_o, cnt_busy_o
    );

    // Reporter / frontend side.
    modport master (
        output r_err_valid_i, r_err_addr_i, w_err_valid_i, w_err_addr_i,
               be_err_valid_i, be_err_addr_i, err_ready_i, eh_valid_i, eh_i,
        input  r_err_ready_o, w_err_ready_o, be_err_ready_o, err_valid_o,
               err_type_o, err_addr_o, eh_ready_o, abort_o, fsm_busy_o, cnt_busy_o
    );
endinterface

// File: rtl/idma_err_collector_sva.sv
// Protocol checks on the collector's frontend outputs.
module idma_err_collector_sva import idma_pkg::*; #(
    parameter int unsigned AddrWidth = 32
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 err_valid_i,
    input logic                 err_ready_i,
    input err_type_t            err_type_i,
    input logic [AddrWidth-1:0] err_addr_i,
    input logic                 abort_i
);
    a_report_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (err_valid_i && !err_ready_i) |=> ($stable(err_type_i) && $stable(err_addr_i)));

    a_abort_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
        abort_i |=> !abort_i);
endmodule

// File: rtl/idma_err_fifo.sv
// Register-based FIFO for queued error reports; pointers wrap naturally.
module idma_err_fifo #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 34,
    localparam int unsigned PtrW     = $clog2(Depth),
    localparam int unsigned CntW     = PtrW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CntW-1:0]      count_o
);
    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 push_s, pop_s;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == {CntW{1'b0}});
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_s) begin
            wptr_d = wptr_q + PtrW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PtrW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= {PtrW{1'b0}};
            rptr_q <= {PtrW{1'b0}};
            cnt_q  <= {CntW{1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Report storage, cleared on reset so stale reports never resurface.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= {DataWidth{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wptr_q] <= data_i;
        end
    end
endmodule

// File: rtl/idma_err_collector.sv
// Collects read/write/backend error reports, queues them and hands them to
// the frontend one at a time, pulsing abort toward the backend on request.
module idma_err_collector import idma_pkg::*; #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned ErrFifoDepth = 4,
    parameter error_cap_e  ErrorCap     = ERROR_HANDLING
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    idma_err_collector_if.slave  bus
);
    localparam int unsigned CntW = $clog2(ErrFifoDepth) + 1;

    typedef struct packed {
        err_type_t            err_type;
        logic [AddrWidth-1:0] addr;
    } err_rep_t;

    if (ErrorCap == ERROR_HANDLING) begin : gen_eh
        eh_state_e       state_q, state_d;
        err_rep_t        push_rep_s, head_rep_s;
        logic            grant_w_s, grant_r_s, grant_be_s;
        logic            full_s, empty_s, push_s, pop_s;
        logic            rdy_w_s, rdy_r_s, rdy_be_s;
        logic [CntW-1:0] count_s;

        // Fixed-priority grant: write beats read beats backend.
        always_comb begin
            grant_w_s  = 1'b0;
            grant_r_s  = 1'b0;
            grant_be_s = 1'b0;
            push_rep_s = '0;
            if (bus.w_err_valid_i) begin
                grant_w_s  = 1'b1;
                push_rep_s = '{err_type: err_type_t'(BUS_WRITE), addr: bus.w_err_addr_i};
            end else if (bus.r_err_valid_i) begin
                grant_r_s  = 1'b1;
                push_rep_s = '{err_type: err_type_t'(BUS_READ), addr: bus.r_err_addr_i};
            end else if (bus.be_err_valid_i) begin
                grant_be_s = 1'b1;
                push_rep_s = '{err_type: err_type_t'(BACKEND), addr: bus.be_err_addr_i};
            end else begin
                push_rep_s = '0;
            end
        end

        // A full queue refuses everyone, even when the head pops this cycle.
        assign rdy_w_s  = grant_w_s  & ~full_s & rst_ni;
        assign rdy_r_s  = grant_r_s  & ~full_s & rst_ni;
        assign rdy_be_s = grant_be_s & ~full_s & rst_ni;
        assign push_s   = rdy_w_s | rdy_r_s | rdy_be_s;
        assign pop_s    = (state_q == EH_WAIT_ACT) & bus.eh_valid_i;

        assign bus.w_err_ready_o  = rdy_w_s;
        assign bus.r_err_ready_o  = rdy_r_s;
        assign bus.be_err_ready_o = rdy_be_s;

        idma_err_fifo #(
            .Depth     (ErrFifoDepth),
            .DataWidth ($bits(err_rep_t))
        ) i_err_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push_s),
            .data_i  (push_rep_s),
            .pop_i   (pop_s),
            .data_o  (head_rep_s),
            .full_o  (full_s),
            .empty_o (empty_s),
            .count_o (count_s)
        );

        // FSM state register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= EH_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // FSM next-state logic.
        always_comb begin
            state_d = state_q;
            case (state_q)
                EH_IDLE: begin
                    if (!empty_s) state_d = EH_REPORT;
                    else          state_d = EH_IDLE;
                end
                EH_REPORT: begin
                    if (bus.err_ready_i) state_d = EH_WAIT_ACT;
                    else                 state_d = EH_REPORT;
                end
                EH_WAIT_ACT: begin
                    if (bus.eh_valid_i) begin
                        if (bus.eh_i == ABORT) state_d = EH_ABORT;
                        else                   state_d = EH_IDLE;
                    end else begin
                        state_d = EH_WAIT_ACT;
                    end
                end
                EH_ABORT: state_d = EH_IDLE;
                default:  state_d = EH_IDLE;
            endcase
        end

        // FSM outputs: report fields are only driven while presenting.
        always_comb begin
            bus.err_valid_o = 1'b0;
            bus.err_type_o  = 2'd0;
            bus.err_addr_o  = {AddrWidth{1'b0}};
            bus.eh_ready_o  = 1'b0;
            bus.abort_o     = 1'b0;
            case (state_q)
                EH_REPORT: begin
                    bus.err_valid_o = 1'b1;
                    bus.err_type_o  = head_rep_s.err_type;
                    bus.err_addr_o  = head_rep_s.addr;
                end
                EH_WAIT_ACT: bus.eh_ready_o = 1'b1;
                EH_ABORT:    bus.abort_o    = 1'b1;
                default:     bus.err_valid_o = 1'b0;
            endcase
        end

        assign bus.fsm_busy_o = (state_q != EH_IDLE);
        assign bus.cnt_busy_o = (count_s != {CntW{1'b0}});

        idma_err_collector_sva #(.AddrWidth(AddrWidth)) i_sva (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .err_valid_i (bus.err_valid_o),
            .err_ready_i (bus.err_ready_i),
            .err_type_i  (bus.err_type_o),
            .err_addr_i  (bus.err_addr_o),
            .abort_i     (bus.abort_o)
        );
    end else begin : gen_no_eh
        // Reports are swallowed; nothing is stored or forwarded.
        logic unused_s;
        assign unused_s = ^{clk_i, rst_ni, bus.r_err_valid_i, bus.r_err_addr_i,
                            bus.w_err_valid_i, bus.w_err_addr_i, bus.be_err_valid_i,
                            bus.be_err_addr_i, bus.err_ready_i, bus.eh_valid_i, bus.eh_i};
        assign bus.r_err_ready_o  = 1'b1;
        assign bus.w_err_ready_o  = 1'b1;
        assign bus.be_err_ready_o = 1'b1;
        assign bus.err_valid_o    = 1'b0;
        assign bus.err_type_o     = 2'd0;
        assign bus.err_addr_o     = {AddrWidth{1'b0}};
        assign bus.eh_ready_o     = 1'b0;
        assign bus.abort_o        = 1'b0;
        assign bus.fsm_busy_o     = 1'b0;
        assign bus.cnt_busy_o     = 1'b0;
    end
endmodule

// File: tb/tb_idma_err_collector.sv
module tb_idma_err_collector;
    import idma_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    idma_err_collector_if #(.AddrWidth(32)) eif ();
    idma_err_collector_if #(.AddrWidth(32)) nif ();

    idma_err_collector #(.AddrWidth(32), .ErrFifoDepth(4), .ErrorCap(ERROR_HANDLING)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(eif));
    idma_err_collector #(.AddrWidth(32), .ErrFifoDepth(4), .ErrorCap(NO_ERROR_HANDLING)) dut_noeh (
        .clk_i(clk), .rst_ni(rst_n), .bus(nif));

    typedef struct packed { logic [1:0] t; logic [31:0] a; } rep_t;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        eif.r_err_valid_i = 1'b0; eif.w_err_valid_i = 1'b0; eif.be_err_valid_i = 1'b0;
        eif.r_err_addr_i = 32'd0; eif.w_err_addr_i = 32'd0; eif.be_err_addr_i = 32'd0;
        eif.err_ready_i = 1'b0; eif.eh_valid_i = 1'b0; eif.eh_i = CONTINUE;
    endtask

    // Waits for a report, accepts it, then answers with the given action.
    task automatic serve_one(input eh_action_e act, output logic [1:0] typ,
                             output logic [31:0] addr, output bit ok);
        ok = 1'b0; typ = 2'd0; addr = 32'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (eif.err_valid_o === 1'b1) begin
                ok = 1'b1; typ = eif.err_type_o; addr = eif.err_addr_o;
                break;
            end
            tick();
        end
        if (ok) begin
            eif.err_ready_i = 1'b1; tick(); eif.err_ready_i = 1'b0;
            eif.eh_valid_i = 1'b1; eif.eh_i = act; tick();
            eif.eh_valid_i = 1'b0; eif.eh_i = CONTINUE;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        eif.r_err_valid_i = 1'b1; eif.w_err_valid_i = 1'b1; eif.be_err_valid_i = 1'b1;
        #1;
        n_checks++;
        if ({eif.r_err_ready_o, eif.w_err_ready_o, eif.be_err_ready_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 000",
                {eif.r_err_ready_o, eif.w_err_ready_o, eif.be_err_ready_o});
        end
        n_checks++;
        if ({eif.err_valid_o, eif.err_type_o, eif.err_addr_o, eif.eh_ready_o, eif.abort_o,
             eif.fsm_busy_o, eif.cnt_busy_o} !== 39'd0) begin
            n_fail++; $display("FAIL reset_outputs: valid=%b type=%0d addr=%h ehr=%b abort=%b busy=%b%b want all 0",
                eif.err_valid_o, eif.err_type_o, eif.err_addr_o, eif.eh_ready_o, eif.abort_o,
                eif.fsm_busy_o, eif.cnt_busy_o);
        end
        tick(); tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        eif.r_err_valid_i = 1'b1; eif.r_err_addr_i = 32'h1000_0040;
        @(negedge clk);
        n_checks++;
        if (eif.r_err_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", eif.r_err_ready_o); end
        tick(); eif.r_err_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (eif.err_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early: err_valid %b at t+1 want 0", eif.err_valid_o); end
        tick();
        @(negedge clk);
        n_checks++;
        if ({eif.err_valid_o, eif.err_type_o, eif.err_addr_o} !== {1'b1, 2'd0, 32'h1000_0040}) begin
            n_fail++; $display("FAIL single_report: got v=%b t=%0d a=%h want v=1 t=0 a=10000040",
                eif.err_valid_o, eif.err_type_o, eif.err_addr_o);
        end
        tick(); eif.err_ready_i = 1'b1; tick(); eif.err_ready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (eif.eh_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_eh_ready: got %b want 1", eif.eh_ready_o); end
        tick(); eif.eh_valid_i = 1'b1; eif.eh_i = CONTINUE; tick(); eif.eh_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({eif.abort_o, eif.fsm_busy_o, eif.cnt_busy_o} !== 3'b000) begin
                n_fail++; $display("FAIL single_after: abort/fsm/cnt = %b%b%b want 000",
                    eif.abort_o, eif.fsm_busy_o, eif.cnt_busy_o);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        logic [1:0] typ; logic [31:0] addr; bit ok;
        logic [1:0]  exp_t [3] = '{2'd1, 2'd0, 2'd2};
        logic [31:0] exp_a [3] = '{32'hB, 32'hA, 32'hC};
        eif.r_err_valid_i = 1'b1; eif.r_err_addr_i = 32'hA;
        eif.w_err_valid_i = 1'b1; eif.w_err_addr_i = 32'hB;
        eif.be_err_valid_i = 1'b1; eif.be_err_addr_i = 32'hC;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({eif.w_err_ready_o, eif.r_err_ready_o, eif.be_err_ready_o} !== (3'b100 >> k)) begin
                n_fail++; $display("FAIL prio_grant%0d: w/r/be ready %b%b%b want %b", k,
                    eif.w_err_ready_o, eif.r_err_ready_o, eif.be_err_ready_o, 3'b100 >> k);
            end
            tick();
            if (k == 0) eif.w_err_valid_i = 1'b0;
            else if (k == 1) eif.r_err_valid_i = 1'b0;
            else eif.be_err_valid_i = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            serve_one(CONTINUE, typ, addr, ok);
            n_checks++;
            if (!ok || typ !== exp_t[k] || addr !== exp_a[k]) begin
                n_fail++; $display("FAIL prio_order%0d: ok=%0d t=%0d a=%h want t=%0d a=%h",
                    k, ok, typ, addr, exp_t[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic [1:0] typ; logic [31:0] addr; bit ok;
        eif.w_err_valid_i = 1'b1; eif.w_err_addr_i = 32'h2000;
        tick(); eif.w_err_valid_i = 1'b0;
        serve_one(ABORT, typ, addr, ok);
        n_checks++;
        if (!ok || typ !== 2'd1 || addr !== 32'h2000) begin
            n_fail++; $display("FAIL abort_report: ok=%0d t=%0d a=%h want t=1 a=2000", ok, typ, addr);
        end
        @(negedge clk);
        n_checks++;
        if (eif.abort_o !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b want 1", eif.abort_o); end
        tick();
        @(negedge clk);
        n_checks++;
        if ({eif.abort_o, eif.fsm_busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL abort_end: abort/fsm %b%b want 00", eif.abort_o, eif.fsm_busy_o);
        end
        tick();
    endtask

    task automatic test_full();
        logic [1:0] typ; logic [31:0] addr; bit ok;
        for (int i = 0; i < 5; i++) begin
            eif.r_err_valid_i = 1'b1; eif.r_err_addr_i = 32'(32'h100 + i);
            @(negedge clk);
            n_checks++;
            if (eif.r_err_ready_o !== (i < 4)) begin
                n_fail++; $display("FAIL full_accept%0d: ready %b want %b", i, eif.r_err_ready_o, i < 4);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if ({eif.r_err_ready_o, eif.cnt_busy_o} !== 2'b01) begin
            n_fail++; $display("FAIL full_hold: ready/cnt %b%b want 01", eif.r_err_ready_o, eif.cnt_busy_o);
        end
        tick();
        serve_one(CONTINUE, typ, addr, ok);
        n_checks++;
        if (!ok || typ !== 2'd0 || addr !== 32'h100) begin
            n_fail++; $display("FAIL full_first: ok=%0d t=%0d a=%h want t=0 a=100", ok, typ, addr);
        end
        @(negedge clk);
        n_checks++;
        if (eif.r_err_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_reopen: ready %b want 1", eif.r_err_ready_o); end
        tick(); eif.r_err_valid_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            serve_one(CONTINUE, typ, addr, ok);
            n_checks++;
            if (!ok || addr !== 32'(32'h100 + i)) begin
                n_fail++; $display("FAIL full_drain%0d: ok=%0d a=%h want a=%h", i, ok, addr, 32'h100 + i);
            end
        end
        @(negedge clk);
        n_checks++;
        if (eif.cnt_busy_o !== 1'b0) begin n_fail++; $display("FAIL full_empty: cnt_busy %b want 0", eif.cnt_busy_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eif.be_err_valid_i = 1'b1; eif.be_err_addr_i = 32'(32'h30 + i);
            tick();
        end
        eif.be_err_valid_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (eif.err_valid_o === 1'b1);
            tick();
        end
        eif.err_ready_i = 1'b1; tick(); eif.err_ready_i = 1'b0;
        n_checks++;
        if (!seen || eif.eh_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup: seen=%0d eh_ready=%b want 1/1", seen, eif.eh_ready_o);
        end
        eif.r_err_valid_i = 1'b1; eif.w_err_valid_i = 1'b1; eif.be_err_valid_i = 1'b1;
        eif.eh_valid_i = 1'b1; eif.eh_i = ABORT;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({eif.r_err_ready_o, eif.w_err_ready_o, eif.be_err_ready_o, eif.err_valid_o,
             eif.eh_ready_o, eif.abort_o, eif.fsm_busy_o, eif.cnt_busy_o} !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: r/w/be/v/ehr/abort/fsm/cnt=%b%b%b%b%b%b%b%b want 0",
                eif.r_err_ready_o, eif.w_err_ready_o, eif.be_err_ready_o, eif.err_valid_o,
                eif.eh_ready_o, eif.abort_o, eif.fsm_busy_o, eif.cnt_busy_o);
        end
        tick(); idle_inputs(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({eif.err_valid_o, eif.abort_o, eif.fsm_busy_o, eif.cnt_busy_o} !== 4'b0000) begin
                n_fail++; $display("FAIL rstmid_after%0d: v/abort/fsm/cnt %b%b%b%b want 0000", i,
                    eif.err_valid_o, eif.abort_o, eif.fsm_busy_o, eif.cnt_busy_o);
            end
            tick();
        end
    endtask

    // Random traffic against a queue model of the collector.
    task automatic test_random();
        rep_t q[$];
        bit   awaiting = 1'b0, abort_exp = 1'b0, next_abort, full;
        bit   exp_w, exp_r, exp_be, drain;
        rep_t hd;
        for (int cyc = 0; cyc < 460; cyc++) begin
            drain = (cyc >= 400);
            eif.w_err_valid_i  = !drain && ($urandom_range(0, 3) == 0);
            eif.r_err_valid_i  = !drain && ($urandom_range(0, 2) == 0);
            eif.be_err_valid_i = !drain && ($urandom_range(0, 2) == 0);
            eif.w_err_addr_i = $urandom; eif.r_err_addr_i = $urandom; eif.be_err_addr_i = $urandom;
            eif.err_ready_i = drain || ($urandom_range(0, 1) == 1);
            eif.eh_valid_i  = drain || ($urandom_range(0, 2) != 0);
            eif.eh_i = (!drain && $urandom_range(0, 2) == 0) ? ABORT : CONTINUE;
            @(negedge clk);
            full   = (q.size() >= 4);
            exp_w  = eif.w_err_valid_i && !full;
            exp_r  = eif.r_err_valid_i && !eif.w_err_valid_i && !full;
            exp_be = eif.be_err_valid_i && !eif.w_err_valid_i && !eif.r_err_valid_i && !full;
            n_checks++;
            if ({eif.w_err_ready_o, eif.r_err_ready_o, eif.be_err_ready_o} !== {exp_w, exp_r, exp_be}) begin
                n_fail++; $display("FAIL rnd_ready c%0d: w/r/be %b%b%b want %b%b%b", cyc,
                    eif.w_err_ready_o, eif.r_err_ready_o, eif.be_err_ready_o, exp_w, exp_r, exp_be);
            end
            n_checks++;
            if (eif.abort_o !== abort_exp) begin n_fail++; $display("FAIL rnd_abort c%0d: got %b want %b", cyc, eif.abort_o, abort_exp); end
            n_checks++;
            if (eif.eh_ready_o !== awaiting) begin n_fail++; $display("FAIL rnd_eh_ready c%0d: got %b want %b", cyc, eif.eh_ready_o, awaiting); end
            n_checks++;
            if (eif.cnt_busy_o !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_cnt_busy c%0d: got %b want %b", cyc, eif.cnt_busy_o, q.size() != 0);
            end
            n_checks++;
            if (eif.fsm_busy_o !== (eif.err_valid_o | eif.eh_ready_o | eif.abort_o)) begin
                n_fail++; $display("FAIL rnd_fsm_busy c%0d: got %b", cyc, eif.fsm_busy_o);
            end
            if (eif.err_valid_o === 1'b1) begin
                n_checks++;
                if (awaiting || q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious c%0d: report with awaiting=%0d qsize=%0d", cyc, awaiting, q.size());
                end else begin
                    hd = q[0];
                    if ({eif.err_type_o, eif.err_addr_o} !== {hd.t, hd.a}) begin
                        n_fail++; $display("FAIL rnd_report c%0d: t=%0d a=%h want t=%0d a=%h", cyc,
                            eif.err_type_o, eif.err_addr_o, hd.t, hd.a);
                    end
                end
            end
            next_abort = awaiting && eif.eh_valid_i && (eif.eh_i == ABORT);
            if (awaiting && eif.eh_valid_i) begin
                void'(q.pop_front()); awaiting = 1'b0;
            end else if (eif.err_valid_o === 1'b1 && eif.err_ready_i) begin
                awaiting = 1'b1;
            end
            if (exp_w)       q.push_back('{t: 2'd1, a: eif.w_err_addr_i});
            else if (exp_r)  q.push_back('{t: 2'd0, a: eif.r_err_addr_i});
            else if (exp_be) q.push_back('{t: 2'd2, a: eif.be_err_addr_i});
            abort_exp = next_abort;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (q.size() != 0 || eif.cnt_busy_o !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain: model left %0d, cnt_busy %b want 0/0", q.size(), eif.cnt_busy_o);
        end
        tick();
    endtask

    task automatic test_no_eh();
        for (int i = 0; i < 20; i++) begin
            nif.r_err_valid_i = $urandom_range(0, 1); nif.w_err_valid_i = $urandom_range(0, 1);
            nif.be_err_valid_i = $urandom_range(0, 1);
            nif.r_err_addr_i = $urandom; nif.w_err_addr_i = $urandom; nif.be_err_addr_i = $urandom;
            nif.err_ready_i = $urandom_range(0, 1); nif.eh_valid_i = $urandom_range(0, 1);
            nif.eh_i = ABORT;
            @(negedge clk);
            n_checks++;
            if ({nif.r_err_ready_o, nif.w_err_ready_o, nif.be_err_ready_o, nif.err_valid_o,
                 nif.abort_o, nif.eh_ready_o, nif.fsm_busy_o, nif.cnt_busy_o} !== 8'b1110_0000) begin
                n_fail++; $display("FAIL noeh_c%0d: r/w/be/v/abort/ehr/fsm/cnt=%b%b%b%b%b%b%b%b want 11100000", i,
                    nif.r_err_ready_o, nif.w_err_ready_o, nif.be_err_ready_o, nif.err_valid_o,
                    nif.abort_o, nif.eh_ready_o, nif.fsm_busy_o, nif.cnt_busy_o);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        nif.r_err_valid_i = 1'b0; nif.w_err_valid_i = 1'b0; nif.be_err_valid_i = 1'b0;
        nif.r_err_addr_i = 32'd0; nif.w_err_addr_i = 32'd0; nif.be_err_addr_i = 32'd0;
        nif.err_ready_i = 1'b0; nif.eh_valid_i = 1'b0; nif.eh_i = CONTINUE;
        test_reset();
        test_single_read();
        test_priority();
        test_abort();
        test_full();
        test_reset_mid();
        test_random();
        test_no_eh();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/idma_err_collector.md
Name: idma_err_collector

Overview:
- Collects bus and backend error reports from the iDMA read leg, write leg and backend length check.
- Queues each report with its err_type_e tag and faulting address.
- Presents reports one at a time to the frontend/register file and waits for an eh_action_e response.
- Sits downstream of the transport legs and upstream of the frontend. Emits a one-cycle abort pulse toward the backend on ABORT. Feeds the eh_fsm_busy/eh_cnt_busy fields of idma_busy_t.

Parameters:
- AddrWidth, 32, width of reported fault address
- ErrFifoDepth, 4, queued error reports; power of two, >= 2
- ErrorCap, idma_pkg::ERROR_HANDLING, NO_ERROR_HANDLING removes all storage

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- r_err_valid_i  in  1  read-leg error report valid
- r_err_addr_i  in  AddrWidth  read fault address
- r_err_ready_o  out  1  read report accepted
- w_err_valid_i  in  1  write-leg error report valid
- w_err_addr_i  in  AddrWidth  write fault address
- w_err_ready_o  out  1  write report accepted
- be_err_valid_i  in  1  backend zero-length error valid
- be_err_addr_i  in  AddrWidth  source address of offending transfer
- be_err_ready_o  out  1  backend report accepted
- err_valid_o  out  1  error report to frontend valid
- err_type_o  out  2  idma_pkg::err_type_t tag
- err_addr_o  out  AddrWidth  fault address
- err_ready_i  in  1  frontend accepted report
- eh_valid_i  in  1  action valid
- eh_i  in  1  idma_pkg::eh_action_e (CONTINUE/ABORT)
- eh_ready_o  out  1  action accepted
- abort_o  out  1  one-cycle abort pulse to backend
- fsm_busy_o  out  1  FSM not IDLE
- cnt_busy_o  out  1  FIFO non-empty

Behaviour:
- Reset: FIFO empty, FSM IDLE, pointers/count 0.
- Reset values: all *_ready_o 0 while rst_ni low. err_valid_o=0, err_type_o=0, err_addr_o=0, eh_ready_o=0, abort_o=0, busy outputs 0.
- Reset mid-operation discards every queued report and any pending abort.
- Input arbitration: at most one push per cycle. Fixed priority BUS_WRITE > BUS_READ > BACKEND.
- Only the granted source sees ready=1, and only when count<ErrFifoDepth.
- Full FIFO: all readies 0, even if a pop occurs the same cycle (no push-on-full-pop).
- Push stores {err_type, addr}: BUS_READ for r, BUS_WRITE for w, BACKEND for be.
- FSM states:
  - IDLE: if FIFO non-empty, go to REPORT next cycle.
  - REPORT: err_valid_o=1, outputs driven from FIFO head and stable until err_ready_i. On handshake, go to WAIT_ACT.
  - WAIT_ACT: eh_ready_o=1. On eh_valid_i, pop head.
    - If eh_i==ABORT, go to ABORT; otherwise go to IDLE.
  - ABORT: abort_o=1 for exactly this cycle, then IDLE.
- Latency: report pushed at cycle t appears on err_valid_o at t+2 when FIFO was empty and FSM IDLE.
- Throughput: one report per 3 cycles (CONTINUE), 4 cycles (ABORT).
- ABORT does not flush other queued reports; they are reported normally afterwards.
- Simultaneous push and pop in WAIT_ACT are allowed when not full; count unchanged.
- Pointers wrap modulo ErrFifoDepth. Count is log2(ErrFifoDepth)+1 bits.
- fsm_busy_o = state!=IDLE. cnt_busy_o = count!=0 (combinational).
- ErrorCap==NO_ERROR_HANDLING: all *_ready_o tied 1, reports dropped; all outputs constant 0, no flops.
- Assertions:
  - err_type_o/err_addr_o stable while err_valid_o && !err_ready_i.
  - abort_o never high two consecutive cycles.

Decomposition:
- idma_pkg provides err_type_e, err_type_t, eh_action_e, error_cap_e, idma_busy_t.
- Add to idma_pkg a packed struct idma_err_report_t {err_type_t err_type; logic [63:0] addr;}, truncated locally to AddrWidth.
- One natural sub-module: idma_err_fifo (depth-parameterised, register-based, full/empty/count outputs), instantiated once.

Test Plan:
- Single read error, addr 0x1000_0040, FIFO empty → err_valid_o at t+2 with type BUS_READ(0), addr 0x1000_0040. Respond CONTINUE → abort_o never asserts, busy outputs 0 afterwards.
- r, w and be valid same cycle (0xA, 0xB, 0xC) → accepted over 3 cycles in order BUS_WRITE/0xB, BUS_READ/0xA, BACKEND/0xC. Reported in that order.
- Write error 0x2000, action ABORT → abort_o high exactly one cycle, the cycle after eh handshake. FSM then IDLE.
- Push 5 read errors with err_ready_i=0, depth 4 → 4 accepted, r_err_ready_o low on 5th until first pop. No report lost or duplicated.
- Assert rst_ni low while in WAIT_ACT with 3 queued → all outputs 0 immediately, no abort_o, queue empty after release.
- ErrorCap=NO_ERROR_HANDLING, inject errors on all sources → readies always 1, err_valid_o/abort_o stay 0.
